// File: rtl/sdram_pixel_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pixel_burst_writer
//  Description : Buffers a 16-bit camera pixel stream in a FWFT FIFO and
//                feeds it to the SDRAM controller as full-page write bursts.
//                Page addresses advance per burst and wrap at end of frame.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_pixel_burst_writer #(
   parameter int BURST_LEN   = 512,
   parameter int FIFO_DEPTH  = 1024,
   parameter int PAGE_W      = 15,
   parameter int FRAME_PAGES = 600
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic                          i_pix_valid,
   input  logic [15:0]                   i_pix_data,
   input  logic                          i_frame_start,
   input  logic                          i_sdram_ready,
   input  logic                          i_sdram_writing,
   output logic                          o_sdram_en,
   output logic                          o_sdram_rw,
   output logic [PAGE_W-1:0]             o_sdram_addr,
   output logic [15:0]                   o_sdram_data,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic                          o_frame_done,
   output logic                          o_busy
);

   localparam int AW          = $clog2(FIFO_DEPTH);
   localparam int BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int LAST_BEAT_I = BURST_LEN - 1;
   localparam int LAST_PAGE_I = FRAME_PAGES - 1;

   localparam logic [AW:0]       FULL_LEVEL  = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]       BURST_LEVEL = BURST_LEN[AW:0];
   localparam logic [BW-1:0]     LAST_BEAT   = LAST_BEAT_I[BW-1:0];
   localparam logic [PAGE_W-1:0] LAST_PAGE   = LAST_PAGE_I[PAGE_W-1:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BURST = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [15:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         level;
   logic [BW-1:0]       beat;
   logic [PAGE_W-1:0]   page;
   logic [PAGE_W-1:0]   addr;
   logic                pending;
   logic                overflow;
   logic                frame_done;

   logic                full;
   logic                pop;
   logic                push;
   logic                last_beat;
   logic                clear_pending;
   logic                load_addr;
   logic                req_en;
   logic                busy;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts a push then
   assign full      = (level == FULL_LEVEL);
   assign pop       = (state == BURST) && i_sdram_writing;
   assign push      = i_pix_valid && (!full || pop);
   assign last_beat = pop && (beat == LAST_BEAT);

   // Next-state and request outputs
   always_comb begin
      state_next    = state;
      req_en        = 1'b0;
      busy          = 1'b0;
      clear_pending = 1'b0;
      load_addr     = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               clear_pending = 1'b1;
            end else if ((level >= BURST_LEVEL) && i_sdram_ready) begin
               state_next = REQ;
               load_addr  = 1'b1;
            end
         end
         REQ: begin
            req_en     = 1'b1;
            busy       = 1'b1;
            state_next = BURST;
         end
         BURST: begin
            busy = 1'b1;
            if (last_beat) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FIFO storage; contents need no reset because pointers define validity
   always_ff @(posedge i_clk) begin
      if (i_rstn && push) begin
         mem[wr_ptr] <= i_pix_data;
      end
   end

   // FIFO pointers, fill level and sticky overflow
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (i_pix_valid && !push) overflow <= 1'b1;
      end
   end

   // Beat counter, page/address bookkeeping and frame-start handling
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         beat       <= '0;
         page       <= '0;
         addr       <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (state == REQ)  beat <= '0;
         else if (pop)      beat <= beat + 1'b1;

         if (load_addr) addr <= page;

         if (i_frame_start)      pending <= 1'b1;
         else if (clear_pending) pending <= 1'b0;

         frame_done <= last_beat && (page == LAST_PAGE);

         if (clear_pending) begin
            page <= '0;
         end else if (last_beat) begin
            // A pending frame start restarts the frame instead of advancing
            if (pending || (page == LAST_PAGE)) page <= '0;
            else                                page <= page + 1'b1;
         end
      end
   end

   assign o_sdram_en   = req_en;
   assign o_sdram_rw   = 1'b0;
   assign o_sdram_addr = addr;
   assign o_sdram_data = mem[rd_ptr];
   assign o_fifo_level = level;
   assign o_overflow   = overflow;
   assign o_frame_done = frame_done;
   assign o_busy       = busy;

endmodule
`default_nettype wire
